sdram_arbiter: RTL and testbench

- Shares the single-port SDRAM controller among three requesters: P0 CPU (fixed highest priority), P1 video, and P2 loader/DMA. P1 and P2 alternate round-robin.
- Mirrors the controller's 8-cycle clkref-synchronised slot. It presents one access per slot, captures read data, and returns a one-cycle ack.
- It forces an idle slot periodically, so the controller's auto-refresh is never starved.

---
 rtl/sdram_arbiter_if.sv | 39 +++
 rtl/sdram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Requester and controller-side bus of the SDRAM slot arbiter.
// The arbiter uses the slave modport; requesters and controller use master.
interface sdram_arbiter_if;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DS_W   = 2;

    logic              p0_req, p1_req, p2_req;
    logic              p0_we,  p1_we,  p2_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr, p2_addr;
    logic [DATA_W-1:0] p0_din,  p1_din,  p2_din;
    logic [DS_W-1:0]   p0_ds,   p1_ds,   p2_ds;
    logic              p0_ack,  p1_ack,  p2_ack;
    logic [DATA_W-1:0] p0_dout, p1_dout, p2_dout;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DS_W-1:0]   mem_ds;
    logic              mem_oe;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;
    logic [1:0]        grant;

    modport slave (
        input  p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
        input  p0_addr, p1_addr, p2_addr, p0_din, p1_din, p2_din,
        input  p0_ds, p1_ds, p2_ds, mem_dout,
        output p0_ack, p1_ack, p2_ack, p0_dout, p1_dout, p2_dout,
        output mem_addr, mem_din, mem_ds, mem_oe, mem_we, grant
    );

    modport master (
        output p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
        output p0_addr, p1_addr, p2_addr, p0_din, p1_din, p2_din,
        output p0_ds, p1_ds, p2_ds, mem_dout,
        input  p0_ack, p1_ack, p2_ack, p0_dout, p1_dout, p2_dout,
        input  mem_addr, mem_din, mem_ds, mem_oe, mem_we, grant
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM slot arbiter: P0 fixed priority, P1/P2 round-robin, with
// forced refresh slots, following the controller's 8-cycle clkref slot.
module sdram_arbiter #(
    parameter int unsigned REFRESH_INTERVAL = 8,
    parameter int unsigned DATA_PHASE       = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clkref,
    sdram_arbiter_if.slave bus
);
    localparam int unsigned NPORT   = 3;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DS_W    = 2;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned BUSY_W  = 4;

    localparam logic [1:0]         GRANT_IDLE = 2'd3;
    localparam logic [PHASE_W-1:0] PHASE_LAST = '1;
    localparam logic [PHASE_W-1:0] PHASE_DATA = PHASE_W'(DATA_PHASE);
    localparam logic [BUSY_W-1:0]  BUSY_MAX   = BUSY_W'(REFRESH_INTERVAL);

    logic                r_clkref_d;
    logic [PHASE_W-1:0]  r_phase;
    logic [BUSY_W-1:0]   r_busy;
    logic                r_rr;
    logic [1:0]          r_grant;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_din;
    logic [DS_W-1:0]     r_mem_ds;
    logic                r_mem_oe;
    logic                r_mem_we;
    logic [NPORT-1:0]    r_ack;
    logic [DATA_W-1:0]   r_dout [NPORT];

    logic [NPORT-1:0]    w_req;
    logic [NPORT-1:0]    w_elig;
    logic                w_rise;
    logic                w_slot_end;
    logic                w_resync;
    logic                w_refresh;
    logic                w_complete;
    logic [1:0]          w_next_grant;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_din;
    logic [DS_W-1:0]     w_sel_ds;

    assign w_req      = {bus.p2_req, bus.p1_req, bus.p0_req};
    assign w_rise     = clkref & ~r_clkref_d;
    assign w_slot_end = (r_phase == PHASE_LAST);
    assign w_resync   = w_rise & ~w_slot_end;
    assign w_refresh  = (r_busy == BUSY_MAX);
    // A port acked in the ending slot is still holding req; mask it for one slot.
    assign w_elig     = w_req & ~r_ack;
    assign w_complete = (r_phase == PHASE_DATA) & ~w_resync & (r_grant != GRANT_IDLE);

    // Winner of the next slot.
    always_comb begin
        w_next_grant = GRANT_IDLE;
        if (!w_refresh) begin
            if (w_elig[0])
                w_next_grant = 2'd0;
            else if (w_elig[1] && (!w_elig[2] || !r_rr))
                w_next_grant = 2'd1;
            else if (w_elig[2])
                w_next_grant = 2'd2;
        end
    end

    // Qualifiers of the winning port.
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        w_sel_ds   = '0;
        case (w_next_grant)
            2'd0: begin
                w_sel_we = bus.p0_we; w_sel_addr = bus.p0_addr;
                w_sel_din = bus.p0_din; w_sel_ds = bus.p0_ds;
            end
            2'd1: begin
                w_sel_we = bus.p1_we; w_sel_addr = bus.p1_addr;
                w_sel_din = bus.p1_din; w_sel_ds = bus.p1_ds;
            end
            2'd2: begin
                w_sel_we = bus.p2_we; w_sel_addr = bus.p2_addr;
                w_sel_din = bus.p2_din; w_sel_ds = bus.p2_ds;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clkref_d <= 1'b0;
            r_phase    <= '0;
            r_busy     <= '0;
            r_rr       <= 1'b0;
            r_grant    <= GRANT_IDLE;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_ds   <= '0;
            r_mem_oe   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_ack      <= '0;
            for (int i = 0; i < NPORT; i++) r_dout[i] <= '0;
        end else begin
            r_clkref_d <= clkref;
            r_phase    <= w_rise ? '0 : r_phase + PHASE_W'(1);
            r_ack      <= '0;

            // Resync leaves grant and mem_* untouched so the slot is re-presented.
            if (w_slot_end) begin
                r_grant <= w_next_grant;
                if (w_next_grant == GRANT_IDLE) begin
                    r_mem_oe <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_busy   <= '0;
                end else begin
                    r_mem_addr <= w_sel_addr;
                    r_mem_din  <= w_sel_din;
                    r_mem_ds   <= w_sel_ds;
                    r_mem_we   <= w_sel_we;
                    r_mem_oe   <= ~w_sel_we;
                    r_busy     <= (r_busy >= BUSY_MAX) ? r_busy : r_busy + BUSY_W'(1);
                    if (w_next_grant == 2'd1)
                        r_rr <= 1'b1;
                    else if (w_next_grant == 2'd2)
                        r_rr <= 1'b0;
                end
            end

            if (w_complete) begin
                for (int i = 0; i < NPORT; i++) begin
                    if (r_grant == 2'(i)) begin
                        r_ack[i] <= 1'b1;
                        if (!r_mem_we) r_dout[i] <= bus.mem_dout;
                    end
                end
            end
        end
    end

    assign bus.grant    = r_grant;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_ds   = r_mem_ds;
    assign bus.mem_oe   = r_mem_oe;
    assign bus.mem_we   = r_mem_we;
    assign bus.p0_ack   = r_ack[0];
    assign bus.p1_ack   = r_ack[1];
    assign bus.p2_ack   = r_ack[2];
    assign bus.p0_dout  = r_dout[0];
    assign bus.p1_dout  = r_dout[1];
    assign bus.p2_dout  = r_dout[2];
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized
// run against a slot-level reference model.
module tb_sdram_arbiter;
    localparam int unsigned RI = 8;
    localparam int unsigned DP = 6;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clkref  = 1'b0;
    initial forever #5 clk = ~clk;

    sdram_arbiter_if bus ();

    sdram_arbiter #(.REFRESH_INTERVAL(RI), .DATA_PHASE(DP)) dut (
        .clk(clk), .reset_n(reset_n), .clkref(clkref), .bus(bus)
    );

    logic        t_req  [3];
    logic        t_we   [3];
    logic [23:0] t_addr [3];
    logic [15:0] t_din  [3];
    logic [1:0]  t_ds   [3];
    logic [15:0] t_mem_dout;

    assign bus.p0_req = t_req[0];  assign bus.p1_req = t_req[1];  assign bus.p2_req = t_req[2];
    assign bus.p0_we  = t_we[0];   assign bus.p1_we  = t_we[1];   assign bus.p2_we  = t_we[2];
    assign bus.p0_addr = t_addr[0]; assign bus.p1_addr = t_addr[1]; assign bus.p2_addr = t_addr[2];
    assign bus.p0_din = t_din[0];  assign bus.p1_din = t_din[1];  assign bus.p2_din = t_din[2];
    assign bus.p0_ds  = t_ds[0];   assign bus.p1_ds  = t_ds[1];   assign bus.p2_ds  = t_ds[2];
    assign bus.mem_dout = t_mem_dout;

    logic [2:0]  d_ack;
    logic [15:0] d_dout [3];
    assign d_ack     = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
    assign d_dout[0] = bus.p0_dout;
    assign d_dout[1] = bus.p1_dout;
    assign d_dout[2] = bus.p2_dout;

    int n_pass  = 0;
    int n_total = 0;
    int ref_ctr = 1;

    // Slot-level reference model state
    int          m_phase, m_busy, m_rr, m_grant;
    logic        m_clkref_d, m_oe, m_we;
    logic [23:0] m_addr;
    logic [15:0] m_din;
    logic [1:0]  m_ds;
    logic [2:0]  m_ack;
    logic [15:0] m_dout [3];

    task automatic model_reset();
        m_phase = 0; m_busy = 0; m_rr = 0; m_grant = 3; m_clkref_d = 1'b0;
        m_oe = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0; m_ds = '0; m_ack = '0;
        for (int p = 0; p < 3; p++) m_dout[p] = '0;
    endtask

    task automatic model_edge();
        logic       rise;
        logic [2:0] elig, new_ack;
        int         order [3];
        int         g;
        rise = clkref && !m_clkref_d;
        for (int p = 0; p < 3; p++) elig[p] = t_req[p] && !m_ack[p];
        new_ack = '0;
        if (m_phase == int'(DP) && !rise && m_grant != 3) begin
            new_ack[m_grant] = 1'b1;
            if (!m_we) m_dout[m_grant] = t_mem_dout;
        end
        if (m_phase == 7) begin
            order = '{0, (m_rr != 0) ? 2 : 1, (m_rr != 0) ? 1 : 2};
            g = 3;
            if (m_busy < int'(RI))
                for (int k = 0; k < 3; k++) if (g == 3 && elig[order[k]]) g = order[k];
            m_grant = g;
            if (g == 3) begin
                m_oe = 1'b0; m_we = 1'b0; m_busy = 0;
            end else begin
                m_addr = t_addr[g]; m_din = t_din[g]; m_ds = t_ds[g];
                m_we = t_we[g]; m_oe = !t_we[g];
                m_busy = (m_busy + 1 > int'(RI)) ? int'(RI) : m_busy + 1;
                if (g == 1) m_rr = 1; else if (g == 2) m_rr = 0;
            end
        end
        m_ack = new_ack;
        m_phase = rise ? 0 : (m_phase + 1) % 8;
        m_clkref_d = clkref;
    endtask

    // One clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        ref_ctr = (ref_ctr + 1) % 8;
        clkref = (ref_ctr == 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ref_ctr = 1;
        clkref  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clkref  = 1'b0;
        for (int p = 0; p < 3; p++) begin
            t_req[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = '0; t_din[p] = '0; t_ds[p] = '0;
        end
        t_mem_dout = '0;
        model_reset();
        release_reset();
    endtask

    task automatic wait_grant(input int g, output bit ok, output int cnt);
        ok = 1'b0;
        cnt = 0;
        for (int k = 0; k < 48; k++) begin
            if (bus.grant === 2'(g)) begin ok = 1'b1; break; end
            tick();
            cnt++;
        end
    endtask

    task automatic slot_advance(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (m_phase == 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (bus.grant !== 2'd3) $display("FAIL reset_grant: got %0d want 3", bus.grant); else n_pass++;
        n_total++; if ({bus.mem_oe, bus.mem_we} !== 2'b00) $display("FAIL reset_oe_we: got %b want 00", {bus.mem_oe, bus.mem_we}); else n_pass++;
        n_total++; if ({bus.mem_addr, bus.mem_din, bus.mem_ds} !== 42'd0) $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_din, bus.mem_ds}); else n_pass++;
        n_total++; if (d_ack !== 3'b000) $display("FAIL reset_ack: got %b want 000", d_ack); else n_pass++;
        n_total++; if ({d_dout[0], d_dout[1], d_dout[2]} !== 48'd0) $display("FAIL reset_dout: got %h want 0", {d_dout[0], d_dout[1], d_dout[2]}); else n_pass++;
    endtask

    task automatic test_single_read();
        bit ok; int cnt;
        do_reset();
        t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 24'h000123; t_din[0] = 16'h0F0F; t_ds[0] = 2'b11;
        t_mem_dout = 16'hBEEF;
        wait_grant(0, ok, cnt);
        n_total++; if (!ok || cnt != 8) $display("FAIL read_grant_latency: got ok=%0d cycles=%0d want ok=1 cycles=8", ok, cnt); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (bus.mem_oe !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 24'h000123)
                $display("FAIL read_slot_bus ph%0d: got oe=%b we=%b addr=%h want oe=1 we=0 addr=000123", i, bus.mem_oe, bus.mem_we, bus.mem_addr);
            else n_pass++;
            n_total++; if (d_ack !== ((i == 7) ? 3'b001 : 3'b000)) $display("FAIL read_ack ph%0d: got %b want %b", i, d_ack, (i == 7) ? 3'b001 : 3'b000); else n_pass++;
            if (i == 7) begin
                n_total++; if (d_dout[0] !== 16'hBEEF) $display("FAIL read_dout: got %h want beef", d_dout[0]); else n_pass++;
                t_req[0] = 1'b0;
            end
            tick();
        end
        n_total++; if (d_ack !== 3'b000) $display("FAIL read_ack_single_cycle: got %b want 000", d_ack); else n_pass++;
    endtask

    task automatic test_priority_rr();
        bit ok;
        int exp_seq [12];
        exp_seq = '{0, 1, 0, 2, 0, 1, 0, 2, 3, 0, 1, 0};
        do_reset();
        for (int p = 0; p < 3; p++) begin
            t_req[p] = 1'b1; t_we[p] = 1'b0; t_addr[p] = 24'($urandom); t_ds[p] = 2'b11;
        end
        for (int s = 0; s < 12; s++) begin
            slot_advance(ok);
            n_total++; if (!ok || bus.grant !== 2'(exp_seq[s]))
                $display("FAIL prio_rr slot%0d: got %0d want %0d", s, bus.grant, exp_seq[s]);
            else n_pass++;
        end
    endtask

    task automatic test_refresh();
        bit ok; int e;
        do_reset();
        t_req[1] = 1'b1; t_we[1] = 1'b0; t_addr[1] = 24'h111111;
        t_req[2] = 1'b1; t_we[2] = 1'b1; t_addr[2] = 24'h222222; t_din[2] = 16'h2222;
        for (int s = 0; s < 18; s++) begin
            slot_advance(ok);
            e = (s % 9 == 8) ? 3 : (((s % 9) % 2 == 0) ? 1 : 2);
            n_total++; if (!ok || bus.grant !== 2'(e)) $display("FAIL refresh slot%0d: got %0d want %0d", s, bus.grant, e); else n_pass++;
            if (e == 3) begin
                n_total++; if ({bus.mem_oe, bus.mem_we} !== 2'b00) $display("FAIL refresh_idle_bus slot%0d: got %b want 00", s, {bus.mem_oe, bus.mem_we}); else n_pass++;
            end
        end
    endtask

    task automatic test_write();
        bit ok; int cnt;
        do_reset();
        t_req[2] = 1'b1; t_we[2] = 1'b1; t_addr[2] = 24'hABCDEF; t_din[2] = 16'h5A5A; t_ds[2] = 2'b01;
        t_mem_dout = 16'h1357;
        wait_grant(2, ok, cnt);
        n_total++; if (!ok) $display("FAIL write_grant: got %0d want 2", bus.grant); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if ({bus.mem_we, bus.mem_oe, bus.mem_addr, bus.mem_din, bus.mem_ds} !== {2'b10, 24'hABCDEF, 16'h5A5A, 2'b01})
                $display("FAIL write_slot_bus ph%0d: got we=%b oe=%b addr=%h din=%h ds=%b want we=1 oe=0 addr=abcdef din=5a5a ds=01",
                         i, bus.mem_we, bus.mem_oe, bus.mem_addr, bus.mem_din, bus.mem_ds);
            else n_pass++;
            if (i == 7) begin
                n_total++; if (d_ack !== 3'b100) $display("FAIL write_ack: got %b want 100", d_ack); else n_pass++;
                n_total++; if (d_dout[2] !== 16'h0000) $display("FAIL write_dout: got %h want 0000", d_dout[2]); else n_pass++;
                t_req[2] = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_resync();
        bit ok; int cnt, acks;
        do_reset();
        t_req[1] = 1'b1; t_we[1] = 1'b0; t_addr[1] = 24'h3C3C3C; t_ds[1] = 2'b10;
        t_mem_dout = 16'h7E7E;
        wait_grant(1, ok, cnt);
        n_total++; if (!ok) $display("FAIL resync_grant: got %0d want 1", bus.grant); else n_pass++;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            acks += int'(d_ack[1]);
            if (i == 3) begin ref_ctr = 0; clkref = 1'b1; end
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            n_total++; if (bus.grant !== 2'd1 || bus.mem_oe !== 1'b1 || bus.mem_addr !== 24'h3C3C3C)
                $display("FAIL resync_hold ph%0d: got grant=%0d oe=%b addr=%h want grant=1 oe=1 addr=3c3c3c", j, bus.grant, bus.mem_oe, bus.mem_addr);
            else n_pass++;
            n_total++; if (d_ack[1] !== (j == 7)) $display("FAIL resync_ack_timing ph%0d: got %b want %b", j, d_ack[1], j == 7); else n_pass++;
            acks += int'(d_ack[1]);
            if (j == 7) begin
                n_total++; if (d_dout[1] !== 16'h7E7E) $display("FAIL resync_dout: got %h want 7e7e", d_dout[1]); else n_pass++;
                t_req[1] = 1'b0;
            end
            tick();
        end
        for (int k = 0; k < 8; k++) begin acks += int'(d_ack[1]); tick(); end
        n_total++; if (acks != 1) $display("FAIL resync_ack_count: got %0d want 1", acks); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok; int cnt;
        do_reset();
        t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 24'h000055; t_mem_dout = 16'h1111;
        wait_grant(0, ok, cnt);
        repeat (7) tick();
        n_total++; if (d_dout[0] !== 16'h1111) $display("FAIL rstmid_first_read: got %h want 1111", d_dout[0]); else n_pass++;
        t_req[0] = 1'b0;
        tick();
        t_req[0] = 1'b1; t_addr[0] = 24'h000066; t_mem_dout = 16'h2222;
        wait_grant(0, ok, cnt);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        n_total++; if (bus.mem_oe !== 1'b0 || bus.grant !== 2'd3 || bus.p0_ack !== 1'b0 || bus.p0_dout !== 16'h0000)
            $display("FAIL rstmid_async: got oe=%b grant=%0d ack=%b dout=%h want oe=0 grant=3 ack=0 dout=0000", bus.mem_oe, bus.grant, bus.p0_ack, bus.p0_dout);
        else n_pass++;
        model_reset();
        clkref = 1'b0;
        release_reset();
        wait_grant(0, ok, cnt);
        n_total++; if (!ok || cnt != 8) $display("FAIL rstmid_regrant: got ok=%0d cycles=%0d want ok=1 cycles=8", ok, cnt); else n_pass++;
        repeat (7) tick();
        n_total++; if (bus.p0_ack !== 1'b1 || bus.p0_dout !== 16'h2222) $display("FAIL rstmid_complete: got ack=%b dout=%h want ack=1 dout=2222", bus.p0_ack, bus.p0_dout); else n_pass++;
        t_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 480; c++) begin
            if (m_phase == 0) begin
                for (int p = 0; p < 3; p++) begin
                    t_req[p] = ($urandom % 4) != 0; t_we[p] = 1'($urandom);
                    t_addr[p] = 24'($urandom); t_din[p] = 16'($urandom); t_ds[p] = 2'($urandom);
                end
            end
            t_mem_dout = 16'($urandom);
            if (clkref == 1'b0 && m_phase >= 1 && m_phase <= 5 && ($urandom % 24) == 0) begin
                ref_ctr = 0; clkref = 1'b1;
            end
            tick();
            n_total++; if (bus.grant !== 2'(m_grant)) $display("FAIL rand_grant c%0d: got %0d want %0d", c, bus.grant, m_grant); else n_pass++;
            n_total++; if ({bus.mem_oe, bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_ds} !== {m_oe, m_we, m_addr, m_din, m_ds})
                $display("FAIL rand_mem c%0d: got %h want %h", c, {bus.mem_oe, bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_ds}, {m_oe, m_we, m_addr, m_din, m_ds});
            else n_pass++;
            n_total++; if (d_ack !== m_ack) $display("FAIL rand_ack c%0d: got %b want %b", c, d_ack, m_ack); else n_pass++;
            n_total++; if ({d_dout[0], d_dout[1], d_dout[2]} !== {m_dout[0], m_dout[1], m_dout[2]})
                $display("FAIL rand_dout c%0d: got %h want %h", c, {d_dout[0], d_dout[1], d_dout[2]}, {m_dout[0], m_dout[1], m_dout[2]});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority_rr();
        test_refresh();
        test_write();
        test_resync();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
